// File: rtl/dp_pkg.sv
// dp_pkg: shared datapath widths and word types for the immediate-extension path.
package dp_pkg;
    localparam int IMM_W = 16;
    localparam int XLEN  = 32;
    typedef logic [IMM_W-1:0] imm_t;
    typedef logic [XLEN-1:0]  word_t;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate widening into sign, zero, upper and branch forms.
module ext_core
    import dp_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = XLEN
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_zext,
    output logic [OUT_W-1:0] out_upper,
    output logic [OUT_W-1:0] out_br
);
    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] w_sext;

    assign w_sext    = {{PAD_W{in[IN_W-1]}}, in};
    assign out       = w_sext;
    assign out_zext  = {{PAD_W{1'b0}}, in};
    assign out_upper = {in, {PAD_W{1'b0}}};
    // Branch offsets are word-aligned; the top two bits fall off the datapath.
    assign out_br    = {w_sext[OUT_W-3:0], 2'b00};
endmodule

// File: rtl/sign_extender.sv
// sign_extender: immediate extension with a one-cycle registered copy of the
// sign-extended value for pipelined/debug consumers.
module sign_extender
    import dp_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_zext,
    output logic [OUT_W-1:0] out_upper,
    output logic [OUT_W-1:0] out_br,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid
);
    generate
        if (IN_W < 2) begin : g_bad_in_w
            $error("sign_extender: IN_W must be >= 2");
        end
        if (OUT_W <= IN_W + 2) begin : g_bad_out_w
            $error("sign_extender: OUT_W must be > IN_W + 2");
        end
    endgenerate

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] r_out_q;
    logic             r_out_valid;

    ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .in        (in),
        .out       (w_sext),
        .out_zext  (out_zext),
        .out_upper (out_upper),
        .out_br    (out_br)
    );

    // out_q holds its last capture while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) r_out_q <= w_sext;
        end
    end

    assign out       = w_sext;
    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_sign_extender.sv
// tb_sign_extender: directed checks of the combinational forms and the registered path.
module tb_sign_extender;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic        in_valid;
    logic [31:0] out, out_zext, out_upper, out_br, out_q;
    logic        out_valid;
    logic [31:0] u_out, u_zext, u_upper, u_br, u_q;
    logic        u_valid;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sign_extender dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .out(out), .out_zext(out_zext), .out_upper(out_upper), .out_br(out_br),
        .out_q(out_q), .out_valid(out_valid)
    );

    // Second copy with clk/rst_n/in_valid left floating.
    sign_extender u_float (
        .clk(1'bz), .rst_n(1'bz), .in(in), .in_valid(1'bz),
        .out(u_out), .out_zext(u_zext), .out_upper(u_upper), .out_br(u_br),
        .out_q(u_q), .out_valid(u_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in = 16'h0000;
        #1;
        chk("rst_out_q", out_q, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);

        in = 16'h7FFF; #1;
        chk("7fff_out", out, 32'h00007FFF);
        chk("7fff_zext", out_zext, 32'h00007FFF);
        chk("7fff_upper", out_upper, 32'h7FFF0000);
        chk("7fff_br", out_br, 32'h0001FFFC);

        in = 16'h8000; #1;
        chk("8000_out", out, 32'hFFFF8000);
        chk("8000_zext", out_zext, 32'h00008000);
        chk("8000_upper", out_upper, 32'h80000000);
        chk("8000_br", out_br, 32'hFFFE0000);
        chk("float_out", u_out, 32'hFFFF8000);

        in = 16'hFFFF; #1;
        chk("ffff_out", out, 32'hFFFFFFFF);
        chk("ffff_zext", out_zext, 32'h0000FFFF);
        chk("ffff_br", out_br, 32'hFFFFFFFC);

        in = 16'h0000; #1;
        chk("0000_out", out, 32'h0);
        chk("0000_zext", out_zext, 32'h0);
        chk("0000_upper", out_upper, 32'h0);
        chk("0000_br", out_br, 32'h0);

        in = 16'h1234; #1;
        chk("1234_upper", out_upper, 32'h12340000);
        chk("1234_br", out_br, 32'h000048D0);

        @(posedge clk); #1;
        chk("rst_hold_q", out_q, 32'h0);
        chk("rst_hold_valid", {31'b0, out_valid}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1; in = 16'h8001; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("cap_q", out_q, 32'hFFFF8001);
        chk("cap_valid", {31'b0, out_valid}, 32'h1);

        @(negedge clk);
        in_valid = 1'b0; in = 16'h0001;
        @(posedge clk); #1;
        chk("hold_q", out_q, 32'hFFFF8001);
        chk("hold_valid", {31'b0, out_valid}, 32'h0);

        @(negedge clk);
        in = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("cap2_q", out_q, 32'h00001234);
        chk("cap2_valid", {31'b0, out_valid}, 32'h1);

        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("midrst_q", out_q, 32'h0);
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1; in = 16'hFFFE;
        @(posedge clk); #1;
        chk("post_rst_q", out_q, 32'hFFFFFFFE);
        chk("post_rst_valid", {31'b0, out_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
